rr_interval_counter_arbiter: RTL and testbench

- Round-robin arbiter that shares one W-bit up-counter between N requesters.
- Each requester asks for an interval of len+1 clock cycles.
- The block grants one requester at a time, runs the shared counter from 0 up to the captured length, pulses that requester's done, then re-arbitrates.
- Sits between the small counter datapaths and the control logic that needs timed intervals.

---
 rtl/rr_interval_counter_arbiter_pkg.sv | 41 ++++
 rtl/rr_interval_counter_arbiter_rr_arb_core.sv | 34 +++
 rtl/rr_interval_counter_arbiter.sv | 107 ++++++++++
 tb/tb_rr_interval_counter_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_interval_counter_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_interval_counter_arbiter_pkg                                      |
// | FSM encoding, defaults and round-robin search for the interval arb.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rr_interval_counter_arbiter_pkg;

  localparam int C_DEFAULT_N = 4;
  localparam int C_DEFAULT_W = 2;
  localparam int C_MAX_N     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // First requester at or above ptr, wrapping modulo n; returns 1 if any found.
  function automatic logic rr_search(
    input  logic [C_MAX_N-1:0] req_vec,
    input  int                 n,
    input  int                 ptr,
    output int                 idx
  );
    logic found;
    int   cand;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < C_MAX_N; k++) begin
      cand = (ptr + k) % n;
      if (k < n && !found && req_vec[cand[2:0]]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return found;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_interval_counter_arbiter_rr_arb_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arb_core                                                          |
// | Combinational round-robin pick of one requester from a pointer.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arb_core
  import rr_interval_counter_arbiter_pkg::*;
#(
  parameter int N = C_DEFAULT_N
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] winner,
  output logic                 valid
);

  localparam int PW = $clog2(N);

  logic [C_MAX_N-1:0] w_req_ext;
  int                 w_idx;
  logic               w_found;

  always_comb begin
    w_req_ext         = '0;
    w_req_ext[N-1:0]  = req;
    w_found           = rr_search(w_req_ext, N, int'(ptr), w_idx);
  end

  assign winner = PW'(w_idx);
  assign valid  = w_found;

endmodule
`default_nettype wire

// File: rtl/rr_interval_counter_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_interval_counter_arbiter                                          |
// | Round-robin sharing of one W-bit interval counter among N requesters.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_interval_counter_arbiter
  import rr_interval_counter_arbiter_pkg::*;
#(
  parameter int N = C_DEFAULT_N,
  parameter int W = C_DEFAULT_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] len,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic           busy,
  output logic [W-1:0]   count_out
);

  localparam int PW = $clog2(N);

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_owner, w_owner_nxt;
  logic [PW-1:0]   r_ptr,   w_ptr_nxt;
  logic [W-1:0]    r_target, w_target_nxt;
  logic [W-1:0]    r_count,  w_count_nxt;
  logic [PW-1:0]   w_winner;
  logic            w_valid;
  logic [PW-1:0]   w_owner_inc;
  logic [N-1:0]    w_owner_hot;

  rr_arb_core #(
    .N (N)
  ) u_rr_arb_core (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_winner),
    .valid  (w_valid)
  );

  assign w_owner_inc = (r_owner == PW'(N - 1)) ? '0 : r_owner + PW'(1);
  assign w_owner_hot = N'(1) << r_owner;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_target <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_ptr    <= w_ptr_nxt;
      r_target <= w_target_nxt;
      r_count  <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_ptr_nxt    = r_ptr;
    w_target_nxt = r_target;
    w_count_nxt  = r_count;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_state_nxt  = ST_RUN;
          w_owner_nxt  = w_winner;
          w_target_nxt = len[w_winner*W +: W];
          w_count_nxt  = '0;
        end
      end
      ST_RUN: begin
        // Abandon is tested first so it overrides a coincident terminal count.
        if (!req[r_owner]) begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
          w_ptr_nxt   = w_owner_inc;
        end else if (r_count == r_target) begin
          w_state_nxt = ST_DONE;
          w_count_nxt = '0;
          w_ptr_nxt   = w_owner_inc;
        end else begin
          w_count_nxt = r_count + W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign grant     = (r_state == ST_RUN)  ? w_owner_hot : '0;
  assign done      = (r_state == ST_DONE) ? w_owner_hot : '0;
  assign busy      = (r_state != ST_IDLE);
  assign count_out = r_count;

endmodule
`default_nettype wire

// File: tb/tb_rr_interval_counter_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rr_interval_counter_arbiter                                       |
// | Directed plus random bench against a behavioural interval model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rr_interval_counter_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  logic           clk   = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [N*W-1:0] len   = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   count_out;

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_en      = 1'b0;

  // Model: who owns the counter (-1 none), elapsed count, who is in its done cycle.
  int m_owner  = -1;
  int m_done   = -1;
  int m_ptr    = 0;
  int m_count  = 0;
  int m_target = 0;
  int m_cand;

  always #5 clk = ~clk;

  rr_interval_counter_arbiter #(
    .N (N),
    .W (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .len       (len),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .count_out (count_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_owner = -1;
        m_done  = -1;
        m_ptr   = 0;
        m_count = 0;
      end else if (m_done >= 0) begin
        m_done = -1;
      end else if (m_owner >= 0) begin
        if (!req[m_owner]) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_count = 0;
        end else if (m_count == m_target) begin
          m_done  = m_owner;
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_count = 0;
        end else begin
          m_count++;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          m_cand = (m_ptr + k) % N;
          if (m_owner < 0 && req[m_cand]) begin
            m_owner  = m_cand;
            m_target = int'(len[m_cand*W +: W]);
            m_count  = 0;
          end
        end
      end
    end
  end

  initial begin
    logic [N-1:0] e_grant;
    logic [N-1:0] e_done;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        e_grant = '0;
        e_done  = '0;
        if (m_owner >= 0) e_grant[m_owner] = 1'b1;
        if (m_done >= 0)  e_done[m_done]   = 1'b1;
        check("model_grant", 32'(grant), 32'(e_grant));
        check("model_done",  32'(done),  32'(e_done));
        check("model_busy",  32'(busy),  32'(m_owner >= 0 || m_done >= 0));
        check("model_count", 32'(count_out), 32'(m_count));
      end
    end
  end

  initial begin
    logic [N-1:0] e;
    repeat (2) cyc();
    check("reset_grant", 32'(grant), 0);
    check("reset_done",  32'(done),  0);
    check("reset_busy",  32'(busy),  0);
    check("reset_count", 32'(count_out), 0);
    reset  = 1'b1;
    cmp_en = 1'b1;

    // Single requester, len 2
    req = 4'b0001; len = 8'h02;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t1_grant", 32'(grant), 32'd1);
      check("t1_count", 32'(count_out), 32'(i));
    end
    cyc();
    check("t1_done",  32'(done),  32'd1);
    check("t1_grant_off", 32'(grant), 0);
    req = '0;
    cyc();
    check("t1_idle", 32'(busy), 0);

    // All requesting, len 0, pointer from reset
    reset = 1'b0; cyc(); reset = 1'b1;
    req = 4'hf; len = '0;
    for (int i = 0; i < 5; i++) begin
      e = 4'b0001 << (i % 4);
      cyc();
      check("t2_grant", 32'(grant), 32'(e));
      cyc();
      check("t2_done", 32'(done), 32'(e));
      if (i == 4) req = '0;
      cyc();
      check("t2_gap", 32'(busy), 0);
    end

    // Abandon by requester 2 at count 1
    req = 4'b0100; len = 8'h30;
    cyc();
    check("t3_grant", 32'(grant), 32'h4);
    cyc();
    check("t3_count", 32'(count_out), 32'd1);
    req = '0;
    cyc();
    check("t3_grant_off", 32'(grant), 0);
    check("t3_no_done",   32'(done),  0);
    check("t3_count_clr", 32'(count_out), 0);
    req = 4'hf; len = '0;
    cyc();
    check("t3_next_rr", 32'(grant), 32'h8);
    req = '0;
    cyc();
    check("t3_no_done2", 32'(done), 0);

    // Async reset mid-run
    req = 4'b0001; len = 8'h03;
    repeat (3) cyc();
    check("t4_count", 32'(count_out), 32'd2);
    #2 reset = 1'b0; req = 4'b0100;
    #1;
    check("t4_grant", 32'(grant), 0);
    check("t4_done",  32'(done),  0);
    check("t4_busy",  32'(busy),  0);
    check("t4_count", 32'(count_out), 0);
    cyc(); reset = 1'b1;
    cyc();
    check("t4_regrant", 32'(grant), 32'h4);
    req = '0;
    cyc();

    // Length change during run is ignored
    req = 4'b0010; len = 8'h04;
    cyc();
    check("t5_grant", 32'(grant), 32'h2);
    len = 8'h0C;
    cyc();
    check("t5_count", 32'(count_out), 32'd1);
    cyc();
    check("t5_done", 32'(done), 32'h2);
    req = '0;
    cyc();

    // Maximum length
    req = 4'b0001; len = 8'h03;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t6_grant", 32'(grant), 32'd1);
      check("t6_count", 32'(count_out), 32'(i));
    end
    cyc();
    check("t6_done", 32'(done), 32'd1);
    req = '0;
    cyc();

    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      cyc();
      if (!reset) begin
        reset = 1'b1;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (req[i]) begin
            if (done[i] || $urandom_range(15) == 0) req[i] = 1'b0;
          end else if ($urandom_range(2) == 0) begin
            req[i] = 1'b1;
          end
        end
        len = N*W'($urandom);
        if ($urandom_range(79) == 0) begin
          #2 reset = 1'b0;
        end
      end
    end

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
